icap_config_ctrl: RTL and testbench
===================================

ICAP_CONFIG_CTRL -- requirements
Module: icap_config_ctrl

Interface
REQ-001 Parameter SWAP_BITS, default 1, meaning: 1 = reverse the bit order within each byte of every word driven to the ICAP; 0 = pass words unchanged.
REQ-002 Parameter CNT_W, default 24, meaning: width of word_count.
REQ-003 Port CLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 Port RST  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle request to begin a configuration session; sampled only in IDLE.
REQ-006 Port abort  input  1  terminate the stream early; honoured only in STREAM.
REQ-007 Port word_count  input  CNT_W  number of payload words; captured on the cycle start is accepted.
REQ-008 Port din  input  32  payload word.
REQ-009 Port din_valid  input  1  din holds a valid word.
REQ-010 Port din_ready  output  1  the block accepts din this cycle.
REQ-011 Port busy  output  1  a session is in progress, i.e. state is not IDLE.
REQ-012 Port done  output  1  one-cycle pulse when a session ends.
REQ-013 Port error  output  1  sticky flag for the last session; abort occurred.
REQ-014 Port icap_csib  output  1  ICAP chip select, active low.
REQ-015 Port icap_rdwrb  output  1  ICAP direction; 0 = write.
REQ-016 Port icap_i  output  32  ICAP write data.

Function
REQ-017 States SHALL be IDLE, HEAD, STREAM, TAIL and DONE; state SHALL be held in a registered FSM.
REQ-018 IDLE transitions: start=1 -> HEAD; word_count is latched into the remaining-word counter and error is cleared in the same cycle.
REQ-019 HEAD SHALL drive four words on four consecutive cycles: FFFFFFFF, AA995566, 20000000, 20000000. It then goes to STREAM, or directly to TAIL when the latched count is 0.
REQ-020 STREAM: din_ready SHALL be 1 only in STREAM and only while the remaining count is nonzero.
REQ-021 STREAM: a word is accepted when din_valid and din_ready are both 1; each accepted word decrements the counter.
REQ-022 STREAM: when the last word is accepted, the next state SHALL be TAIL.
REQ-023 STREAM with din_valid=0: icap_csib SHALL be 1 for that cycle (bubble), and no word is written.
REQ-024 TAIL SHALL drive four words on four consecutive cycles: 30008001, 0000000D, 20000000, 20000000 (CMD write, DESYNC, NOOP, NOOP). It then goes to DONE.
REQ-025 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-026 Output timing: all ICAP outputs SHALL be registered. A word accepted or generated in cycle N appears on icap_i, with icap_csib=0, in cycle N+1. In any cycle with no word, icap_csib=1.
REQ-027 icap_rdwrb SHALL be 0 at all times after reset; the block performs writes only.
REQ-028 Bit swap: with SWAP_BITS=1, icap_i bit 8k+j SHALL equal source bit 8k+(7-j). The swap applies to header, payload and trailer words alike; AA995566 is therefore emitted as 5599AA66.
REQ-029 Abort in STREAM SHALL set error=1 and move to TAIL on the next edge; a word accepted in the same cycle as abort is still written. Abort in any other state is ignored.
REQ-030 start asserted while busy=1 SHALL be ignored.
REQ-031 Simultaneous start and abort in IDLE: start wins, abort is ignored.
REQ-032 Counter wrap: the counter SHALL never decrement below 0. din_ready=0 whenever the count is 0.
REQ-033 Total icap_csib-low cycles per session SHALL be 8 plus the number of accepted words.

Reset
REQ-034 RST=1 at a rising edge SHALL force: state IDLE, icap_csib=1, icap_rdwrb=0, icap_i=0, din_ready=0, busy=0, done=0, error=0, counter=0.
REQ-035 Reset mid-session SHALL abandon the session without emitting the trailer; the first post-reset cycle already shows icap_csib=1.
REQ-036 RST SHALL take priority over start and abort in the same cycle.

Verification
REQ-037 Scenario 1: start with word_count=3, SWAP_BITS=0, din_valid held 1, din=11111111/22222222/33333333 -> icap_i sequence FFFFFFFF, AA995566, 20000000, 20000000, 11111111, 22222222, 33333333, 30008001, 0000000D, 20000000, 20000000 on 11 consecutive csib-low cycles; then done pulses once, error=0.
REQ-038 Scenario 2: SWAP_BITS=1, word_count=1, din=000000FF -> second header word 5599AA66; payload emitted as 000000FF; trailer word 0000000D emitted as 000000B0.
REQ-039 Scenario 3: word_count=4 with din_valid toggling 1,0,1,0... -> icap_csib=1 on each bubble cycle; exactly 4 payload words written, in order.
REQ-040 Scenario 4: word_count=10, abort after 2 accepted words -> the 2 words are written, then the 4-word trailer; error=1 and done pulses; error stays 1 until the next start.
REQ-041 Scenario 5: word_count=0 -> 8 consecutive csib-low cycles (header then trailer); din_ready never 1.
REQ-042 Scenario 6: RST asserted during STREAM -> the next cycle shows busy=0, icap_csib=1, din_ready=0; a start after that runs a complete, correct session.

Source files
------------

// File: rtl/icap_config_ctrl.sv
// ICAP write-stream controller: emits a sync header, forwards payload words
// from a valid/ready stream, then a desync trailer, with optional per-byte bit reversal.
module icap_config_ctrl #(
  parameter int SWAP_BITS = 1,
  parameter int CNT_W     = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] word_count,
  input  logic [31:0]      din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             icap_csib,
  output logic             icap_rdwrb,
  output logic [31:0]      icap_i
);

  typedef enum logic [2:0] {IDLE, HEAD, STREAM, TAIL, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              error_q, error_d;
  logic              csib_q, csib_d;
  logic [31:0]       icap_i_q, icap_i_d;
  logic              word_vld;
  logic [31:0]       word;
  logic              accept;

  function automatic logic [31:0] bitswap(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned j = 0; j < 8; j++) begin
        r[8*k+j] = w[8*k+7-j];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] head_word(input logic [1:0] i);
    case (i)
      2'd0:    return 32'hFFFF_FFFF;
      2'd1:    return 32'hAA99_5566;
      default: return 32'h2000_0000;
    endcase
  endfunction

  function automatic logic [31:0] tail_word(input logic [1:0] i);
    case (i)
      2'd0:    return 32'h3000_8001;
      2'd1:    return 32'h0000_000D;
      default: return 32'h2000_0000;
    endcase
  endfunction

  assign din_ready  = (state_q == STREAM) && (cnt_q != '0);
  assign accept     = din_ready && din_valid;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign error      = error_q;
  assign icap_csib  = csib_q;
  assign icap_rdwrb = 1'b0;
  assign icap_i     = icap_i_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    error_d  = error_q;
    word_vld = 1'b0;
    word     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HEAD;
          idx_d   = '0;
          cnt_d   = word_count;
          error_d = 1'b0;
        end
      end
      HEAD: begin
        word_vld = 1'b1;
        word     = head_word(idx_q);
        idx_d    = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = (cnt_q == '0) ? TAIL : STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          word_vld = 1'b1;
          word     = din;
          cnt_d    = cnt_q - CNT_W'(1);
        end
        // abort still lets a same-cycle accepted word through
        if (abort) begin
          state_d = TAIL;
          error_d = 1'b1;
        end else if (accept && (cnt_q == CNT_W'(1))) begin
          state_d = TAIL;
        end
      end
      TAIL: begin
        word_vld = 1'b1;
        word     = tail_word(idx_q);
        idx_d    = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    csib_d   = ~word_vld;
    icap_i_d = icap_i_q;
    if (word_vld) begin
      icap_i_d = (SWAP_BITS != 0) ? bitswap(word) : word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
      csib_q   <= 1'b1;
      icap_i_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
      csib_q   <= csib_d;
      icap_i_q <= icap_i_d;
    end
  end

endmodule

// File: tb/tb_icap_config_ctrl.sv
// Directed bench for icap_config_ctrl: one unswapped and one bit-swapped instance
// share the same stimulus; ICAP writes are captured on the falling edge.
module tb_icap_config_ctrl;

  logic        CLK = 1'b0;
  logic        RST, start, abort, din_valid;
  logic [23:0] word_count;
  logic [31:0] din;

  logic        din_ready0, busy0, done0, error0, csib0, rdwrb0;
  logic [31:0] icap_i0;
  logic        din_ready1, busy1, done1, error1, csib1, rdwrb1;
  logic [31:0] icap_i1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  icap_config_ctrl #(.SWAP_BITS(0), .CNT_W(24)) dut0 (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .word_count(word_count),
    .din(din), .din_valid(din_valid), .din_ready(din_ready0), .busy(busy0),
    .done(done0), .error(error0), .icap_csib(csib0), .icap_rdwrb(rdwrb0), .icap_i(icap_i0)
  );

  icap_config_ctrl #(.SWAP_BITS(1), .CNT_W(24)) dut1 (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .word_count(word_count),
    .din(din), .din_valid(din_valid), .din_ready(din_ready1), .busy(busy1),
    .done(done1), .error(error1), .icap_csib(csib1), .icap_rdwrb(rdwrb1), .icap_i(icap_i1)
  );

  localparam logic [31:0] HDR0  [4] = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h20000000};
  localparam logic [31:0] TAIL0 [4] = '{32'h30008001, 32'h0000000D, 32'h20000000, 32'h20000000};
  localparam logic [31:0] EXP_SW[9] = '{32'hFFFFFFFF, 32'h5599AA66, 32'h04000000, 32'h04000000,
                                        32'h000000FF, 32'h0C000180, 32'h000000B0, 32'h04000000,
                                        32'h04000000};

  logic [31:0] pay [16];
  logic [31:0] exp_q [$];
  logic [31:0] cap0 [$];
  logic [31:0] cap1 [$];
  int          capc0 [$];
  int          cyc = 0;
  int          done_cnt = 0;
  bit          ready_seen = 0;
  int          rdwrb_bad = 0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (csib0 === 1'b0) begin
      cap0.push_back(icap_i0);
      capc0.push_back(cyc);
    end
    if (csib1 === 1'b0) cap1.push_back(icap_i1);
    if (done0 === 1'b1) done_cnt++;
    if (din_ready0 === 1'b1) ready_seen = 1;
    if (!RST && (rdwrb0 !== 1'b0 || rdwrb1 !== 1'b0)) rdwrb_bad++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_caps();
    cap0.delete();
    cap1.delete();
    capc0.delete();
    done_cnt   = 0;
    ready_seen = 0;
  endtask

  function automatic void make_exp(input int npay);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(HDR0[i]);
    for (int i = 0; i < npay; i++) exp_q.push_back(pay[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(TAIL0[i]);
  endfunction

  // Stimulus driver only: runs one session with din_valid held high.
  task automatic run_session(input int n, input bit hold_abort, input int abort_at,
                             input bit hold_start, output bit timeout);
    int k;
    int guard;
    bit acc;
    clear_caps();
    start = 1'b1;
    word_count = 24'(n);
    abort = hold_abort;
    tick();
    start = hold_start;
    word_count = 24'd9;
    k = 0;
    guard = 0;
    while (busy0 && guard < 200) begin
      din = pay[k % 16];
      din_valid = 1'b1;
      abort = hold_abort;
      if (abort_at >= 0 && k == abort_at && din_ready0) begin
        abort = 1'b1;
        din_valid = 1'b0;
      end
      acc = din_valid && din_ready0;
      tick();
      if (acc) k++;
      guard++;
    end
    start = 1'b0;
    abort = 1'b0;
    din_valid = 1'b0;
    timeout = busy0;
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = '0; word_count = '0;
    tick(); tick();
    n_tests++;
    if ({busy0, done0, error0, din_ready0, csib0, rdwrb0} !== 6'b000010) begin
      n_fail++;
      $display("FAIL reset_ctrl0 got %b exp 000010", {busy0, done0, error0, din_ready0, csib0, rdwrb0});
    end
    n_tests++;
    if ({busy1, done1, error1, din_ready1, csib1, rdwrb1} !== 6'b000010) begin
      n_fail++;
      $display("FAIL reset_ctrl1 got %b exp 000010", {busy1, done1, error1, din_ready1, csib1, rdwrb1});
    end
    n_tests++;
    if (icap_i0 !== 32'h0 || icap_i1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_icap_i got %h/%h exp 0", icap_i0, icap_i1);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit to;
    run_session(3, 1'b0, -1, 1'b0, to);
    make_exp(3);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL basic_timeout busy got 1 exp 0"); end
    n_tests++;
    if (cap0.size() !== 11) begin n_fail++; $display("FAIL basic_len got %0d exp 11", cap0.size()); end
    for (int i = 0; i < 11 && i < cap0.size(); i++) begin
      n_tests++;
      if (cap0[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word%0d got %h exp %h", i, cap0[i], exp_q[i]); end
      n_tests++;
      if (capc0[i] !== capc0[0] + i) begin n_fail++; $display("FAIL basic_consec%0d got %0d exp %0d", i, capc0[i], capc0[0] + i); end
    end
    n_tests++;
    if (done_cnt !== 1 || error0 !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_err got %0d/%b exp 1/0", done_cnt, error0);
    end
  endtask

  task automatic test_swap();
    bit to;
    pay[0] = 32'h000000FF;
    run_session(1, 1'b0, -1, 1'b0, to);
    n_tests++;
    if (to || cap1.size() !== 9) begin n_fail++; $display("FAIL swap_len got %0d exp 9", cap1.size()); end
    for (int i = 0; i < 9 && i < cap1.size(); i++) begin
      n_tests++;
      if (cap1[i] !== EXP_SW[i]) begin n_fail++; $display("FAIL swap_word%0d got %h exp %h", i, cap1[i], EXP_SW[i]); end
    end
    pay[0] = 32'h11111111;
  endtask

  task automatic test_bubbles();
    int k = 0;
    int guard = 0;
    bit tog = 1'b1;
    bit bub, acc;
    clear_caps();
    start = 1'b1; word_count = 24'd4;
    tick();
    start = 1'b0;
    while (busy0 && guard < 200) begin
      din = pay[k % 16];
      din_valid = tog;
      bub = din_ready0 && !tog;
      acc = din_ready0 && tog;
      tick();
      if (bub) begin
        n_tests++;
        if (csib0 !== 1'b1) begin n_fail++; $display("FAIL bubble_csib got %b exp 1", csib0); end
      end
      if (acc) begin
        n_tests++;
        if (csib0 !== 1'b0 || icap_i0 !== pay[k]) begin
          n_fail++; $display("FAIL bubble_word%0d got %b/%h exp 0/%h", k, csib0, icap_i0, pay[k]);
        end
        k++;
      end
      tog = ~tog;
      guard++;
    end
    din_valid = 1'b0;
    make_exp(4);
    n_tests++;
    if (busy0 || cap0.size() !== 12) begin n_fail++; $display("FAIL bubble_len got %0d exp 12", cap0.size()); end
    for (int i = 0; i < 12 && i < cap0.size(); i++) begin
      n_tests++;
      if (cap0[i] !== exp_q[i]) begin n_fail++; $display("FAIL bubble_seq%0d got %h exp %h", i, cap0[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    bit to;
    run_session(10, 1'b0, 2, 1'b0, to);
    make_exp(2);
    n_tests++;
    if (to || cap0.size() !== 10) begin n_fail++; $display("FAIL abort_len got %0d exp 10", cap0.size()); end
    for (int i = 0; i < 10 && i < cap0.size(); i++) begin
      n_tests++;
      if (cap0[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_word%0d got %h exp %h", i, cap0[i], exp_q[i]); end
    end
    n_tests++;
    if (done_cnt !== 1 || error0 !== 1'b1) begin
      n_fail++; $display("FAIL abort_done_err got %0d/%b exp 1/1", done_cnt, error0);
    end
    tick(); tick(); tick();
    n_tests++;
    if (error0 !== 1'b1) begin n_fail++; $display("FAIL abort_sticky got %b exp 1", error0); end
  endtask

  // zero-length session; abort held high throughout must have no effect
  task automatic test_zero_count();
    bit to;
    clear_caps();
    start = 1'b1; word_count = '0; abort = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (error0 !== 1'b0 || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL zero_start got err=%b busy=%b exp 0/1", error0, busy0);
    end
    for (int g = 0; g < 50 && busy0; g++) tick();
    abort = 1'b0;
    to = busy0;
    make_exp(0);
    n_tests++;
    if (to || cap0.size() !== 8) begin n_fail++; $display("FAIL zero_len got %0d exp 8", cap0.size()); end
    for (int i = 0; i < 8 && i < cap0.size(); i++) begin
      n_tests++;
      if (cap0[i] !== exp_q[i] || capc0[i] !== capc0[0] + i) begin
        n_fail++; $display("FAIL zero_word%0d got %h exp %h", i, cap0[i], exp_q[i]);
      end
    end
    n_tests++;
    if (ready_seen || error0 !== 1'b0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL zero_flags got ready=%b err=%b done=%0d exp 0/0/1", ready_seen, error0, done_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    run_session(2, 1'b0, -1, 1'b1, to);
    make_exp(2);
    n_tests++;
    if (to || cap0.size() !== 10) begin n_fail++; $display("FAIL busy_start_len got %0d exp 10", cap0.size()); end
    for (int i = 0; i < 10 && i < cap0.size(); i++) begin
      n_tests++;
      if (cap0[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_start_word%0d got %h exp %h", i, cap0[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int guard = 0;
    clear_caps();
    start = 1'b1; word_count = 24'd5;
    tick();
    start = 1'b0;
    din_valid = 1'b1;
    while (!din_ready0 && guard < 20) begin tick(); guard++; end
    din = pay[0];
    tick();
    RST = 1'b1; start = 1'b1; abort = 1'b1;
    tick();
    n_tests++;
    if ({busy0, csib0, din_ready0, done0, error0} !== 5'b01000 || icap_i0 !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid got %b/%h exp 01000/00000000", {busy0, csib0, din_ready0, done0, error0}, icap_i0);
    end
    RST = 1'b0; start = 1'b0; abort = 1'b0; din_valid = 1'b0;
    tick();
    n_tests++;
    if (busy0 !== 1'b0 || csib0 !== 1'b1) begin
      n_fail++; $display("FAIL rst_priority got busy=%b csib=%b exp 0/1", busy0, csib0);
    end
    run_session(3, 1'b0, -1, 1'b0, to);
    make_exp(3);
    n_tests++;
    if (to || cap0.size() !== 11) begin n_fail++; $display("FAIL rst_resume_len got %0d exp 11", cap0.size()); end
    for (int i = 0; i < 11 && i < cap0.size(); i++) begin
      n_tests++;
      if (cap0[i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_resume_word%0d got %h exp %h", i, cap0[i], exp_q[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pay[i] = 32'(i + 1) * 32'h11111111;
    test_reset();
    test_basic();
    test_swap();
    test_bubbles();
    test_abort();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid();
    n_tests++;
    if (rdwrb_bad !== 0) begin n_fail++; $display("FAIL rdwrb got %0d nonzero cycles exp 0", rdwrb_bad); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
